// File: rtl/prog_loader_pkg.sv
// Shared constants and state encodings for the serial program loader and its UART receiver.
package prog_loader_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COUNT,
    S_DATA,
    S_CSUM
  } load_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

endpackage

// File: rtl/prog_loader_uart_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling, glitch rejection on the start bit.
module uart_rx
  import prog_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       rx_in,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

  logic             sync1_q, sync2_q, prev_q;
  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;

  // NOTE: sequential state always uses non-blocking (<=) so every flop samples pre-edge values.
  // Synchroniser resets to the idle-high level so reset release never looks like a start edge.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync1_q <= rx_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  // NOTE: every signal written here gets a default first, otherwise synthesis infers latches.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (prev_q && !sync2_q) state_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = sync2_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shift_d = {sync2_q, shift_q[7:1]};
          if (bit_q == 3'd7) state_d = RX_STOP;
          else               bit_d   = bit_q + 3'd1;
        end
      end
      RX_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          state_d = RX_IDLE;
          valid_d = sync2_q;
          ferr_d  = !sync2_q;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign byte_out   = shift_q;
  assign byte_valid = valid_q;
  assign frame_err  = ferr_q;

endmodule

// File: rtl/prog_loader.sv
// Serial bootloader: parses SYNC/COUNT/data/CSUM frames from a UART and writes words into the
// instruction ROM, holding the processor in reset until a checksum-verified load completes.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int ADDR_BITS    = 8,
  parameter int WORD_WIDTH   = 24,
  parameter int TIMEOUT_CLKS = 2000000
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rx_in,
  output logic                  wr_en_out,
  output logic [ADDR_BITS-1:0]  wr_addr_out,
  output logic [WORD_WIDTH-1:0] wr_data_out,
  output logic                  cpu_rst_out,
  output logic                  busy_out,
  output logic                  done_out,
  output logic                  err_out
);

  localparam int BYTES     = WORD_WIDTH / 8;
  localparam int BIDX_W    = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int WCNT_W    = ADDR_BITS + 1;
  localparam int MAX_WORDS = 1 << ADDR_BITS;
  localparam int TMO_W     = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [BIDX_W-1:0] BIDX_LAST = BIDX_W'(BYTES - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CLKS - 1);

  logic [7:0] rx_byte;
  logic       rx_valid, rx_ferr;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .rx_in      (rx_in),
    .byte_out   (rx_byte),
    .byte_valid (rx_valid),
    .frame_err  (rx_ferr)
  );

  load_state_e           state_q, state_d;
  logic [WCNT_W-1:0]     total_q, total_d;
  logic [WCNT_W-1:0]     widx_q, widx_d;
  logic [BIDX_W-1:0]     bidx_q, bidx_d;
  logic [WORD_WIDTH-1:0] word_q, word_d;
  logic [7:0]            sum_q, sum_d;
  logic [TMO_W-1:0]      tmo_q, tmo_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_BITS-1:0]  wr_addr_q, wr_addr_d;
  logic [WORD_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  cpu_rst_q, cpu_rst_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic [WCNT_W-1:0]     count_words;
  logic [WORD_WIDTH-1:0] next_word;

  // COUNT of zero, or beyond the address space, means a full-ROM load.
  always_comb begin
    count_words = WCNT_W'(MAX_WORDS);
    if (rx_byte != 8'd0 && int'(rx_byte) <= MAX_WORDS) count_words = WCNT_W'(rx_byte);
  end

  assign next_word = (word_q << 8) | WORD_WIDTH'(rx_byte);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q   <= S_IDLE;
      total_q   <= '0;
      widx_q    <= '0;
      bidx_q    <= '0;
      word_q    <= '0;
      sum_q     <= '0;
      tmo_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      cpu_rst_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      total_q   <= total_d;
      widx_q    <= widx_d;
      bidx_q    <= bidx_d;
      word_q    <= word_d;
      sum_q     <= sum_d;
      tmo_q     <= tmo_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      cpu_rst_q <= cpu_rst_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    total_d   = total_q;
    widx_d    = widx_q;
    bidx_d    = bidx_q;
    word_d    = word_q;
    sum_d     = sum_q;
    tmo_d     = (state_q == S_IDLE) ? '0 : tmo_q + TMO_W'(1);
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    cpu_rst_d = cpu_rst_q;
    done_d    = done_q;
    err_d     = err_q;
    // A received byte takes priority over a timeout expiring in the same cycle.
    if (rx_valid) begin
      tmo_d = '0;
      unique case (state_q)
        S_IDLE: begin
          if (rx_byte == SYNC_BYTE) begin
            cpu_rst_d = 1'b1;
            done_d    = 1'b0;
            err_d     = 1'b0;
            widx_d    = '0;
            bidx_d    = '0;
            sum_d     = '0;
            state_d   = S_COUNT;
          end
        end
        S_COUNT: begin
          total_d = count_words;
          state_d = S_DATA;
        end
        S_DATA: begin
          word_d = next_word;
          sum_d  = sum_q + rx_byte;
          if (bidx_q == BIDX_LAST) begin
            bidx_d    = '0;
            wr_en_d   = 1'b1;
            wr_addr_d = widx_q[ADDR_BITS-1:0];
            wr_data_d = next_word;
            widx_d    = widx_q + WCNT_W'(1);
            if (widx_q + WCNT_W'(1) == total_q) state_d = S_CSUM;
          end else begin
            bidx_d = bidx_q + BIDX_W'(1);
          end
        end
        S_CSUM: begin
          if (rx_byte == sum_q) begin
            done_d    = 1'b1;
            cpu_rst_d = 1'b0;
          end else begin
            err_d = 1'b1;
          end
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end else if (state_q != S_IDLE && (rx_ferr || tmo_q == TMO_LAST)) begin
      err_d   = 1'b1;
      tmo_d   = '0;
      state_d = S_IDLE;
    end
  end

  assign wr_en_out   = wr_en_q;
  assign wr_addr_out = wr_addr_q;
  assign wr_data_out = wr_data_q;
  assign cpu_rst_out = cpu_rst_q;
  assign busy_out    = (state_q != S_IDLE);
  assign done_out    = done_q;
  assign err_out     = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed frame scenarios plus random frames against a frame-level model.
module tb_prog_loader;

  localparam int CPB   = 4;
  localparam int TMO   = 200;
  localparam int BYTES = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        rx = 1'b1;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [23:0] wr_data;
  logic        cpu_rst, busy, done, err;

  prog_loader #(
    .CLKS_PER_BIT (CPB),
    .ADDR_BITS    (8),
    .WORD_WIDTH   (24),
    .TIMEOUT_CLKS (TMO)
  ) dut (
    .clk_in      (clk),
    .rst_in      (rst_n),
    .rx_in       (rx),
    .wr_en_out   (wr_en),
    .wr_addr_out (wr_addr),
    .wr_data_out (wr_data),
    .cpu_rst_out (cpu_rst),
    .busy_out    (busy),
    .done_out    (done),
    .err_out     (err)
  );

  always #5 clk = ~clk;

  int          n_vec  = 0;
  int          n_miss = 0;
  logic [31:0] got_q[$];
  logic [23:0] frame_words[256];

  always @(negedge clk) if (rst_n && wr_en) got_q.push_back({wr_addr, wr_data});

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(negedge clk);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_bit;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic glitch();
    @(negedge clk);
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  // Frame-level model: bytes are derived from frame_words, expected writes are (index, word).
  task automatic load_frame(input int count_byte, input bit corrupt, input int glitch_at, input string tag);
    int         n;
    logic [7:0] bytes_q[$];
    logic [7:0] csum;
    logic [7:0] b;
    n = (count_byte == 0) ? 256 : count_byte;
    csum = 8'd0;
    bytes_q.push_back(8'hA5);
    bytes_q.push_back(count_byte[7:0]);
    for (int w = 0; w < n; w++) begin
      for (int k = BYTES - 1; k >= 0; k--) begin
        b = frame_words[w][8*k +: 8];
        bytes_q.push_back(b);
        csum = csum + b;
      end
    end
    bytes_q.push_back(corrupt ? csum + 8'd1 : csum);
    got_q.delete();
    foreach (bytes_q[i]) begin
      if (i == glitch_at) glitch();
      send_byte(bytes_q[i], 1'b1);
      if (i == 0) begin
        repeat (3) @(negedge clk);
        check({tag, " sync busy/cpu_rst/done/err"}, {28'd0, busy, cpu_rst, done, err}, 32'b1100);
      end
    end
    repeat (4) @(negedge clk);
    check({tag, " write count"}, got_q.size(), n);
    for (int i = 0; i < n && i < got_q.size(); i++)
      check($sformatf("%s wr%0d", tag, i), got_q[i], {i[7:0], frame_words[i]});
    check({tag, " end busy/cpu_rst/done/err"}, {28'd0, busy, cpu_rst, done, err},
          {28'd0, 1'b0, corrupt, !corrupt, corrupt});
  endtask

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++) frame_words[i] = 24'($urandom);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1 check("reset outputs", {wr_en, wr_addr, wr_data[22:0]}, 32'd0);
    check("reset flags", {28'd0, busy, cpu_rst, done, err}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // 1: good frame
    frame_words[0] = 24'h123456;
    frame_words[1] = 24'hABCDEF;
    load_frame(2, 1'b0, -1, "good");

    // 2: bad checksum, then a good frame clears err
    load_frame(2, 1'b1, -1, "badcsum");
    load_frame(2, 1'b0, -1, "recover");

    // 3: preamble ignored, in-frame 0xA5 is data
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h12, 1'b1);
    repeat (4) @(negedge clk);
    check("preamble busy", {31'd0, busy}, 32'd0);
    frame_words[0] = 24'h12A534;
    frame_words[1] = 24'hA5A5A5;
    frame_words[2] = 24'h0000A5;
    load_frame(3, 1'b0, -1, "a5data");

    // 4: framing error on 3rd data byte, then glitch on idle line mid-frame
    got_q.delete();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    send_byte(8'h56, 1'b0);
    repeat (4) @(negedge clk);
    check("ferr busy/cpu_rst/done/err", {28'd0, busy, cpu_rst, done, err}, 32'b0101);
    send_byte(8'hAB, 1'b1);
    send_byte(8'hCD, 1'b1);
    send_byte(8'hEF, 1'b1);
    send_byte(8'h03, 1'b1);
    repeat (4) @(negedge clk);
    check("ferr no strobes", got_q.size(), 0);
    check("ferr stays idle", {31'd0, busy}, 32'd0);
    fill_random(4);
    load_frame(4, 1'b0, 5, "glitch");

    // 5: timeout after COUNT
    send_byte(8'hA5, 1'b1);
    send_byte(8'h02, 1'b1);
    repeat (150) @(negedge clk);
    check("tmo not yet", {28'd0, busy, cpu_rst, done, err}, 32'b1100);
    repeat (60) @(negedge clk);
    check("tmo busy/cpu_rst/done/err", {28'd0, busy, cpu_rst, done, err}, 32'b0101);

    // 6: asynchronous reset mid-S_DATA
    send_byte(8'hA5, 1'b1);
    send_byte(8'h05, 1'b1);
    for (int i = 0; i < 4; i++) send_byte(8'(8'h31 + i), 1'b1);
    repeat (3) @(negedge clk);
    check("pre-reset busy", {31'd0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1 check("async reset outputs", {wr_en, wr_addr, wr_data[22:0]}, 32'd0);
    check("async reset flags", {28'd0, busy, cpu_rst, done, err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    fill_random(2);
    load_frame(2, 1'b0, -1, "postrst");

    // Random frames
    for (int f = 0; f < 6; f++) begin
      int cnt;
      cnt = $urandom_range(1, 12);
      fill_random(cnt);
      load_frame(cnt, ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1) ? $urandom_range(2, 3 * cnt + 2) : -1,
                 $sformatf("rand%0d", f));
    end

    // Full-ROM load: COUNT=0 means 256 words, addresses 0..255
    fill_random(256);
    load_frame(0, 1'b0, -1, "full");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d miscompares so far", n_miss);
    $fatal(1);
  end

endmodule
